// File: rtl/miriscv_lsu_split.sv
// Load/store unit for the miriscv RV32 core: req/gnt/rvalid data bus, pipeline stall,
// and hardware splitting of misaligned accesses into two aligned word beats.
module miriscv_lsu_split #(
    parameter int unsigned ADDR_W           = 32,
    parameter bit          MISALIGNED_SPLIT = 1'b1
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              lsu_req_i,
    input  logic              lsu_we_i,
    input  logic [2:0]        lsu_size_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic [31:0]       lsu_data_i,
    output logic              lsu_stall_req_o,
    output logic [31:0]       lsu_data_o,
    output logic              lsu_err_o,
    output logic              data_req_o,
    input  logic              data_gnt_i,
    input  logic              data_rvalid_i,
    input  logic              data_err_i,
    input  logic [31:0]       data_rdata_i,
    output logic              data_we_o,
    output logic [3:0]        data_be_o,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic [31:0]       data_wdata_o
);

    typedef enum logic [1:0] {IDLE, WAIT0, REQ1, WAIT1} state_t;

    state_t      state;
    logic [31:0] rdata0_q;
    logic        err0_q;

    logic [1:0]        off;
    logic [3:0]        mask;
    logic              size_ok;
    logic [7:0]        wide;
    logic              misaligned;
    logic              split_blocked;
    logic              reject;
    logic              issue0;
    logic              go_req1;
    logic [ADDR_W-1:0] addr_base;
    logic [ADDR_W-1:0] addr_next;
    logic [31:0]       wdata0;
    logic [31:0]       wdata1;

    // Access geometry derived from the held core request
    always_comb begin
        off     = lsu_addr_i[1:0];
        mask    = 4'b0000;
        size_ok = 1'b1;
        case (lsu_size_i)
            3'b000, 3'b100: mask = 4'b0001;
            3'b001, 3'b101: mask = 4'b0011;
            3'b010:         mask = 4'b1111;
            default:        size_ok = 1'b0;
        endcase
        wide          = {4'b0000, mask} << off;
        misaligned    = |wide[7:4];
        split_blocked = misaligned && (MISALIGNED_SPLIT == 1'b0);
        reject        = arstn_i && lsu_req_i && (!size_ok || split_blocked);
        issue0        = arstn_i && lsu_req_i && size_ok && !split_blocked;
        go_req1       = lsu_req_i && misaligned && !data_err_i;
        addr_base     = {lsu_addr_i[ADDR_W-1:2], 2'b00};
        addr_next     = addr_base + ADDR_W'(4);
        wdata0        = lsu_data_i << {off, 3'b000};
        wdata1        = lsu_data_i >> (6'd32 - 6'({off, 3'b000}));
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state    <= IDLE;
            rdata0_q <= 32'd0;
            err0_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (issue0 && data_gnt_i) state <= WAIT0;
                WAIT0: begin
                    if (data_rvalid_i) begin
                        rdata0_q <= data_rdata_i;
                        err0_q   <= data_err_i;
                        state    <= go_req1 ? REQ1 : IDLE;
                    end
                end
                REQ1: begin
                    if (!lsu_req_i)      state <= IDLE;
                    else if (data_gnt_i) state <= WAIT1;
                end
                WAIT1: if (data_rvalid_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    logic        complete;
    logic        load_done;
    logic [31:0] beat0;
    logic [31:0] beat1;

    // Bus drive and completion decode
    always_comb begin
        data_req_o   = 1'b0;
        data_we_o    = 1'b0;
        data_be_o    = 4'b0000;
        data_addr_o  = '0;
        data_wdata_o = 32'd0;
        complete     = 1'b0;
        load_done    = 1'b0;
        lsu_err_o    = 1'b0;
        beat0        = 32'd0;
        beat1        = 32'd0;
        case (state)
            IDLE: begin
                if (issue0) begin
                    data_req_o   = 1'b1;
                    data_we_o    = lsu_we_i;
                    data_be_o    = wide[3:0];
                    data_addr_o  = addr_base;
                    data_wdata_o = wdata0;
                end
                if (reject) begin
                    complete  = 1'b1;
                    lsu_err_o = 1'b1;
                end
            end
            WAIT0: begin
                if (data_rvalid_i && lsu_req_i && !go_req1) begin
                    complete  = 1'b1;
                    load_done = !lsu_we_i;
                    lsu_err_o = data_err_i;
                    beat0     = data_rdata_i;
                end
            end
            REQ1: begin
                if (lsu_req_i && arstn_i) begin
                    data_req_o   = 1'b1;
                    data_we_o    = lsu_we_i;
                    data_be_o    = wide[7:4];
                    data_addr_o  = addr_next;
                    data_wdata_o = wdata1;
                end
            end
            WAIT1: begin
                if (data_rvalid_i && lsu_req_i) begin
                    complete  = 1'b1;
                    load_done = !lsu_we_i;
                    lsu_err_o = err0_q | data_err_i;
                    beat0     = rdata0_q;
                    beat1     = data_rdata_i;
                end
            end
            default: ;
        endcase
        lsu_stall_req_o = lsu_req_i && !complete;
    end

    logic [63:0] pair_sh;
    logic [31:0] sh;
    logic        sgn;

    // Load data alignment and extension
    always_comb begin
        pair_sh = {beat1, beat0} >> {off, 3'b000};
        sh      = pair_sh[31:0];
        sgn     = !lsu_size_i[2];
        case (lsu_size_i[1:0])
            2'b00:   lsu_data_o = {{24{sgn & sh[7]}}, sh[7:0]};
            2'b01:   lsu_data_o = {{16{sgn & sh[15]}}, sh[15:0]};
            default: lsu_data_o = sh;
        endcase
        if (!load_done) lsu_data_o = 32'd0;
    end

endmodule

// File: tb/tb_miriscv_lsu_split.sv
// Directed bench for miriscv_lsu_split: aligned, byte, split, store, error, reset and reject cases.
module tb_miriscv_lsu_split;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        arstn, lsu_req, lsu_we, gnt, rvalid, derr;
    logic [2:0]  lsu_size;
    logic [31:0] lsu_addr, lsu_data, rdata;
    logic        stall, lerr, dreq, dwe;
    logic [31:0] ldata, daddr, dwdata;
    logic [3:0]  dbe;

    logic        req2, gnt2, rvalid2, derr2;
    logic [31:0] rdata2;
    logic        stall2, lerr2, dreq2, dwe2;
    logic [31:0] ldata2, daddr2, dwdata2;
    logic [3:0]  dbe2;

    int n_tests = 0;
    int n_fail  = 0;
    int stalls;

    miriscv_lsu_split #(.ADDR_W(32), .MISALIGNED_SPLIT(1'b1)) dut (
        .clk_i(clk), .arstn_i(arstn), .lsu_req_i(lsu_req), .lsu_we_i(lsu_we),
        .lsu_size_i(lsu_size), .lsu_addr_i(lsu_addr), .lsu_data_i(lsu_data),
        .lsu_stall_req_o(stall), .lsu_data_o(ldata), .lsu_err_o(lerr),
        .data_req_o(dreq), .data_gnt_i(gnt), .data_rvalid_i(rvalid), .data_err_i(derr),
        .data_rdata_i(rdata), .data_we_o(dwe), .data_be_o(dbe), .data_addr_o(daddr),
        .data_wdata_o(dwdata)
    );

    miriscv_lsu_split #(.ADDR_W(32), .MISALIGNED_SPLIT(1'b0)) dut_nosplit (
        .clk_i(clk), .arstn_i(arstn), .lsu_req_i(req2), .lsu_we_i(lsu_we),
        .lsu_size_i(lsu_size), .lsu_addr_i(lsu_addr), .lsu_data_i(lsu_data),
        .lsu_stall_req_o(stall2), .lsu_data_o(ldata2), .lsu_err_o(lerr2),
        .data_req_o(dreq2), .data_gnt_i(gnt2), .data_rvalid_i(rvalid2), .data_err_i(derr2),
        .data_rdata_i(rdata2), .data_we_o(dwe2), .data_be_o(dbe2), .data_addr_o(daddr2),
        .data_wdata_o(dwdata2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        lsu_req = 1'b0; lsu_we = 1'b0; gnt = 1'b0; rvalid = 1'b0; derr = 1'b0;
        rdata = 32'd0; req2 = 1'b0;
    endtask

    initial begin
        idle_bus();
        lsu_size = 3'b010; lsu_addr = 32'h100; lsu_data = 32'd0;
        gnt2 = 1'b0; rvalid2 = 1'b0; derr2 = 1'b0; rdata2 = 32'd0;
        arstn = 1'b0;
        lsu_req = 1'b1;
        #2;
        check("rst_stall_follows_req", 32'(stall), 32'd1);
        check("rst_req", 32'(dreq), 32'd0);
        check("rst_be", 32'(dbe), 32'd0);
        check("rst_addr", daddr, 32'd0);
        check("rst_err", 32'(lerr), 32'd0);
        lsu_req = 1'b0;
        #1;
        check("rst_stall_idle", 32'(stall), 32'd0);
        tick(); tick();
        arstn = 1'b1;

        // aligned lw at 0x100
        lsu_req = 1'b1; lsu_size = 3'b010; lsu_addr = 32'h100; gnt = 1'b1;
        #2;
        check("lw_req", 32'(dreq), 32'd1);
        check("lw_be", 32'(dbe), 32'hF);
        check("lw_addr", daddr, 32'h100);
        check("lw_stall_c0", 32'(stall), 32'd1);
        tick();
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'hDEADBEEF;
        #2;
        check("lw_data", ldata, 32'hDEADBEEF);
        check("lw_stall_c1", 32'(stall), 32'd0);
        check("lw_err", 32'(lerr), 32'd0);
        check("lw_req_c1", 32'(dreq), 32'd0);
        tick(); idle_bus();

        // lb then back-to-back lbu at 0x103
        lsu_req = 1'b1; lsu_size = 3'b000; lsu_addr = 32'h103; gnt = 1'b1;
        #2;
        check("lb_be", 32'(dbe), 32'h8);
        check("lb_addr", daddr, 32'h100);
        tick();
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'h80123456;
        #2;
        check("lb_data", ldata, 32'hFFFFFF80);
        tick();
        lsu_size = 3'b100; gnt = 1'b1; rvalid = 1'b0;
        #2;
        check("lbu_b2b_req", 32'(dreq), 32'd1);
        tick();
        gnt = 1'b0; rvalid = 1'b1;
        #2;
        check("lbu_data", ldata, 32'h00000080);
        tick(); idle_bus();

        // misaligned lw at 0x1002
        stalls = 0;
        lsu_req = 1'b1; lsu_size = 3'b010; lsu_addr = 32'h1002; gnt = 1'b1;
        #2;
        check("mlw_be0", 32'(dbe), 32'hC);
        check("mlw_addr0", daddr, 32'h1000);
        stalls += int'(stall);
        tick();
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'hBBBBAAAA;
        #2;
        check("mlw_req_wait0", 32'(dreq), 32'd0);
        stalls += int'(stall);
        tick();
        gnt = 1'b1; rvalid = 1'b0;
        #2;
        check("mlw_req1", 32'(dreq), 32'd1);
        check("mlw_be1", 32'(dbe), 32'h3);
        check("mlw_addr1", daddr, 32'h1004);
        stalls += int'(stall);
        tick();
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'hDDDDCCCC;
        #2;
        check("mlw_data", ldata, 32'hCCCCBBBB);
        stalls += int'(stall);
        check("mlw_stall_cycles", 32'(stalls), 32'd3);
        tick(); idle_bus();

        // misaligned sh of 0x1234 at 0x2003
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_size = 3'b001; lsu_addr = 32'h2003;
        lsu_data = 32'h1234; gnt = 1'b1;
        #2;
        check("sh_we0", 32'(dwe), 32'd1);
        check("sh_addr0", daddr, 32'h2000);
        check("sh_be0", 32'(dbe), 32'h8);
        check("sh_wdata0", dwdata, 32'h34000000);
        tick();
        gnt = 1'b0; rvalid = 1'b1;
        #2;
        check("sh_stall_wait0", 32'(stall), 32'd1);
        tick();
        gnt = 1'b1; rvalid = 1'b0;
        #2;
        check("sh_addr1", daddr, 32'h2004);
        check("sh_be1", 32'(dbe), 32'h1);
        check("sh_wdata1", dwdata, 32'h00000012);
        tick();
        gnt = 1'b0; rvalid = 1'b1;
        #2;
        check("sh_stall_done", 32'(stall), 32'd0);
        check("sh_ldata_zero", ldata, 32'd0);
        tick(); idle_bus(); lsu_data = 32'd0;

        // misaligned lw, grant delayed 2 cycles, beat-0 bus error
        lsu_req = 1'b1; lsu_size = 3'b010; lsu_addr = 32'h3001;
        #2;
        check("err_req_nogrant", 32'(dreq), 32'd1);
        check("err_be0", 32'(dbe), 32'hE);
        tick();
        #2;
        check("err_addr_held", daddr, 32'h3000);
        check("err_stall_wait", 32'(stall), 32'd1);
        tick();
        gnt = 1'b1;
        tick();
        gnt = 1'b0; rvalid = 1'b1; derr = 1'b1;
        #2;
        check("err_pulse", 32'(lerr), 32'd1);
        check("err_stall_done", 32'(stall), 32'd0);
        tick();
        rvalid = 1'b0; derr = 1'b0;
        #2;
        check("err_no_beat1_addr", daddr, 32'h3000);
        check("err_no_beat1_be", 32'(dbe), 32'hE);
        check("err_pulse_end", 32'(lerr), 32'd0);
        tick(); idle_bus();

        // misaligned lw wrapping past the top of the address space
        lsu_req = 1'b1; lsu_size = 3'b010; lsu_addr = 32'hFFFFFFFE; gnt = 1'b1;
        tick();
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'h11110000;
        tick();
        gnt = 1'b1; rvalid = 1'b0;
        #2;
        check("wrap_addr1", daddr, 32'h0);
        check("wrap_be1", 32'(dbe), 32'h3);
        tick();
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'h00002222;
        #2;
        check("wrap_data", ldata, 32'h22221111);
        tick(); idle_bus();

        // reset asserted while waiting for beat 0
        lsu_req = 1'b1; lsu_size = 3'b010; lsu_addr = 32'h100; gnt = 1'b1;
        tick();
        gnt = 1'b0;
        #2;
        arstn = 1'b0;
        #1;
        check("rstmid_req", 32'(dreq), 32'd0);
        check("rstmid_stall", 32'(stall), 32'd1);
        lsu_req = 1'b0;
        tick();
        arstn = 1'b1;
        lsu_req = 1'b1; lsu_addr = 32'h200; rvalid = 1'b1; rdata = 32'h12345678;
        #2;
        check("late_rvalid_data", ldata, 32'd0);
        check("late_rvalid_stall", 32'(stall), 32'd1);
        check("after_rst_idle_req", 32'(dreq), 32'd1);
        check("after_rst_addr", daddr, 32'h200);
        rvalid = 1'b0; gnt = 1'b1;
        tick();
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'hCAFEF00D;
        #2;
        check("after_rst_data", ldata, 32'hCAFEF00D);
        tick(); idle_bus();

        // illegal size code rejected without a bus request
        lsu_req = 1'b1; lsu_size = 3'b011; lsu_addr = 32'h100;
        #2;
        check("illegal_req", 32'(dreq), 32'd0);
        check("illegal_err", 32'(lerr), 32'd1);
        check("illegal_stall", 32'(stall), 32'd0);
        tick(); idle_bus();

        // split disabled: misaligned lw at 0x1 is rejected
        req2 = 1'b1; lsu_size = 3'b010; lsu_addr = 32'h1;
        #2;
        check("nosplit_req", 32'(dreq2), 32'd0);
        check("nosplit_err", 32'(lerr2), 32'd1);
        check("nosplit_stall", 32'(stall2), 32'd0);
        lsu_addr = 32'h4;
        #1;
        check("nosplit_aligned_req", 32'(dreq2), 32'd1);
        check("nosplit_aligned_err", 32'(lerr2), 32'd0);
        tick(); idle_bus();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
